kb_frame_scheduler: RTL and testbench
=====================================

Name: kb_frame_scheduler

Overview:
Sequences PS/2 key events into the game logic at a fixed point in each video frame, so game state never changes mid-scan. Sits between the debounced keyboard strobe/scan-code path and the VGA controller. Buffers key events in a small FIFO, folds break prefixes into a release flag, and presents at most one event per frame. Presentation starts when the first vertical-blank line is reached and uses a valid/ready handshake.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
VBLANK_LINE, 480, VCOORD value marking the start of vertical blank
BREAK_CODE, 8'hF0, PS/2 break prefix byte

Ports:
CLK  input  1  25 MHz pixel clock, same clock as the VGA controller
RST  input  1  synchronous, active-high reset
KBCODE  input  8  current scan code, stable while KBSTROBE is high
KBSTROBE  input  1  debounced key strobe (level); the rising edge marks a new code
VCOORD  input  10  current vertical pixel coordinate from the encoder
EV_CODE  output  8  presented scan code
EV_RELEASE  output  1  1 = key released (break), 0 = key pressed (make)
EV_VALID  output  1  event presented
EV_READY  input  1  consumer accepts the event when EV_VALID && EV_READY
OVERFLOW  output  1  sticky flag: an event was dropped because the FIFO was full
FIFO_COUNT  output  $clog2(DEPTH)+1  number of entries currently buffered

Behaviour:
- Reset (RST high at a CLK edge) clears all registers:
  - outputs: EV_VALID=0, EV_CODE=0, EV_RELEASE=0, OVERFLOW=0, FIFO_COUNT=0
  - internal: break_pending=0, state=WAIT_TICK, strobe_d=0, vcoord_d=0
  - Reset mid-handshake discards the presented event and all buffered events.
- Strobe edge: strobe_rise = KBSTROBE && !strobe_d, where strobe_d is KBSTROBE registered.
  - A level held high for many cycles yields exactly one rise.
- Capture on strobe_rise:
  - If KBCODE == BREAK_CODE: set break_pending; nothing is enqueued.
  - Otherwise: enqueue {break_pending, KBCODE}, then clear break_pending.
  - Two consecutive BREAK_CODE bytes leave break_pending=1 (idempotent).
- Full FIFO:
  - A push while full and with no pop in the same cycle is dropped and sets OVERFLOW.
  - break_pending is still cleared on a dropped push.
  - OVERFLOW clears only on reset.
- Simultaneous push and pop: both take effect and FIFO_COUNT is unchanged. This holds when the FIFO is full, because the pop frees the slot.
- Frame tick: tick = (VCOORD == VBLANK_LINE) && (vcoord_d != VBLANK_LINE). Exactly one tick per frame.
- FSM:
  - WAIT_TICK: on tick with FIFO_COUNT != 0, load EV_CODE/EV_RELEASE from the FIFO head and go to PRESENT.
    - EV_VALID=1 on the next CLK edge (1-cycle latency from tick).
    - On tick with an empty FIFO, stay in WAIT_TICK; the tick is not remembered.
  - PRESENT: EV_VALID=1; EV_CODE and EV_RELEASE are held stable.
    - On EV_READY: pop the head, EV_VALID=0 next cycle, return to WAIT_TICK.
    - Ticks arriving while in PRESENT are ignored. The event stays presented across frames until accepted, with no skipping.
- At most one handshake per frame. Events pushed after a tick wait for the next tick.
- FIFO pointers wrap modulo DEPTH. FIFO_COUNT saturates at DEPTH by construction.

Optional Feature:
KB_REPEAT_FILTER_EN
- Defined:
  - The block holds last_make (8 bits) and last_valid.
  - A make code equal to last_make while last_valid=1 is a typematic repeat and is discarded. It is not enqueued and does not set OVERFLOW.
  - A break for that code (break_pending with a matching KBCODE) clears last_valid.
  - Any other make code updates last_make and sets last_valid=1.
  - Reset clears both registers.
- Undefined: every make code is enqueued, including typematic repeats.

Decomposition:
- Shared package kb_sched_pkg holds:
  - the state enum (WAIT_TICK, PRESENT)
  - the event struct {release, code[7:0]}
  - BREAK_CODE and VBLANK_LINE defaults, reusable by the VGA controller
- One sub-module: kb_event_fifo
  - parameterised by DEPTH, 9-bit entries, synchronous CLK/RST
  - ports: push, pop, din, dout (head, not registered), full, empty, count
- The top level contains the edge detectors, break folding, the optional filter and the FSM.

Test Plan:
1. Strobe code 8'h1D (KBSTROBE held 5 cycles), then drive VCOORD 479->480 -> exactly one entry; EV_VALID rises 1 cycle after the tick with EV_CODE=8'h1D, EV_RELEASE=0; pop on EV_READY; FIFO_COUNT 1->0.
2. Strobe 8'hF0 then 8'h1D -> a single entry with EV_RELEASE=1, EV_CODE=8'h1D; FIFO_COUNT=1, not 2.
3. Push 5 codes (8'h01..8'h05) with DEPTH=4 and no ticks -> FIFO_COUNT=4, OVERFLOW=1; the next four frames present 8'h01..8'h04 in order, one per frame; 8'h05 is never presented.
4. Hold EV_READY=0 for 3 frames while presenting 8'h1C -> EV_VALID stays 1 with stable data; FIFO_COUNT unchanged; after EV_READY=1, the second entry is presented only at the next tick.
5. With the FIFO full, assert push and the EV_READY pop in the same cycle -> the push is accepted, FIFO_COUNT stays 4, OVERFLOW stays 0.
6. RST during PRESENT with 3 entries buffered -> next cycle EV_VALID=0, FIFO_COUNT=0, OVERFLOW=0. With KB_REPEAT_FILTER_EN, strobe 8'h1D, 8'h1D, 8'h1D, F0, 1D, 1D -> 3 entries enqueued: make 1D, break 1D, make 1D.

Source files
------------

// File: rtl/kb_sched_pkg.sv
// Shared types and defaults for the frame-synchronous keyboard scheduler.
// The VGA controller can reuse VBLANK_LINE_DEF and VCOORD_W.
package kb_sched_pkg;

  localparam int unsigned KB_CODE_W = 8;
  localparam int unsigned VCOORD_W  = 10;

  localparam logic [KB_CODE_W-1:0] BREAK_CODE_DEF  = 8'hF0;
  localparam logic [VCOORD_W-1:0]  VBLANK_LINE_DEF = 10'd480;

  typedef enum logic {
    WAIT_TICK = 1'b0,
    PRESENT   = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic                 is_release;
    logic [KB_CODE_W-1:0] code;
  } kb_event_t;

endpackage

// File: rtl/kb_event_fifo.sv
// Small power-of-two FIFO of key events with an unregistered head and an occupancy count.
module kb_event_fifo
  import kb_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  kb_event_t              din_i,
  output kb_event_t              dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  kb_event_t     mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/kb_frame_scheduler.sv
// Buffers PS/2 key events and presents at most one per video frame, starting at vertical blank.
// Define KB_REPEAT_FILTER_EN to discard typematic repeats of the last make code.
module kb_frame_scheduler
  import kb_sched_pkg::*;
#(
  parameter int unsigned          DEPTH       = 4,
  parameter logic [VCOORD_W-1:0]  VBLANK_LINE = VBLANK_LINE_DEF,
  parameter logic [KB_CODE_W-1:0] BREAK_CODE  = BREAK_CODE_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [KB_CODE_W-1:0]   KBCODE,
  input  logic                   KBSTROBE,
  input  logic [VCOORD_W-1:0]    VCOORD,
  output logic [KB_CODE_W-1:0]   EV_CODE,
  output logic                   EV_RELEASE,
  output logic                   EV_VALID,
  input  logic                   EV_READY,
  output logic                   OVERFLOW,
  output logic [$clog2(DEPTH):0] FIFO_COUNT
);

  logic                strobe_d_q;
  logic [VCOORD_W-1:0] vcoord_d_q;
  logic                break_pending_q, break_pending_d;
  logic                overflow_q, overflow_d;
  sched_state_e        state_q, state_d;
  logic                ev_valid_q, ev_valid_d;
  kb_event_t           ev_q, ev_d;

  logic      strobe_rise;
  logic      is_break;
  logic      tick;
  logic      repeat_drop;
  logic      push;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  kb_event_t fifo_head;
  kb_event_t fifo_din;

  assign strobe_rise = KBSTROBE && !strobe_d_q;
  assign is_break    = (KBCODE == BREAK_CODE);
  assign tick        = (VCOORD == VBLANK_LINE) && (vcoord_d_q != VBLANK_LINE);
  assign push        = strobe_rise && !is_break && !repeat_drop;
  assign fifo_din    = '{is_release: break_pending_q, code: KBCODE};

`ifdef KB_REPEAT_FILTER_EN
  logic [KB_CODE_W-1:0] last_make_q, last_make_d;
  logic                 last_valid_q, last_valid_d;
  logic                 matches_last;

  assign matches_last = last_valid_q && (KBCODE == last_make_q);

  // Breaks always pass; a make equal to the held key is a typematic repeat.
  always_comb begin
    last_make_d  = last_make_q;
    last_valid_d = last_valid_q;
    repeat_drop  = 1'b0;
    if (strobe_rise && !is_break) begin
      if (break_pending_q) begin
        if (matches_last) begin
          last_valid_d = 1'b0;
        end
      end else if (matches_last) begin
        repeat_drop = 1'b1;
      end else begin
        last_make_d  = KBCODE;
        last_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_make_q  <= '0;
      last_valid_q <= 1'b0;
    end else begin
      last_make_q  <= last_make_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  assign repeat_drop = 1'b0;
`endif

  // Break folding and sticky overflow; break_pending clears even when the push is dropped.
  always_comb begin
    break_pending_d = break_pending_q;
    overflow_d      = overflow_q;
    if (strobe_rise) begin
      break_pending_d = is_break;
    end
    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // Presentation FSM: load the head on a frame tick, hold until accepted.
  always_comb begin
    state_d    = state_q;
    ev_d       = ev_q;
    ev_valid_d = ev_valid_q;
    pop        = 1'b0;
    case (state_q)
      WAIT_TICK: begin
        if (tick && !fifo_empty) begin
          ev_d       = fifo_head;
          ev_valid_d = 1'b1;
          state_d    = PRESENT;
        end
      end
      PRESENT: begin
        if (EV_READY) begin
          pop        = 1'b1;
          ev_valid_d = 1'b0;
          state_d    = WAIT_TICK;
        end
      end
      default: begin
        ev_valid_d = 1'b0;
        state_d    = WAIT_TICK;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      strobe_d_q      <= 1'b0;
      vcoord_d_q      <= '0;
      break_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
      state_q         <= WAIT_TICK;
      ev_valid_q      <= 1'b0;
      ev_q            <= '0;
    end else begin
      strobe_d_q      <= KBSTROBE;
      vcoord_d_q      <= VCOORD;
      break_pending_q <= break_pending_d;
      overflow_q      <= overflow_d;
      state_q         <= state_d;
      ev_valid_q      <= ev_valid_d;
      ev_q            <= ev_d;
    end
  end

  kb_event_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (fifo_din),
    .dout_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(FIFO_COUNT)
  );

  assign EV_CODE    = ev_q.code;
  assign EV_RELEASE = ev_q.is_release;
  assign EV_VALID   = ev_valid_q;
  assign OVERFLOW   = overflow_q;

endmodule

// File: tb/tb_kb_frame_scheduler.sv
// Self-checking bench for kb_frame_scheduler against a queue-based event model.
module tb_kb_frame_scheduler;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RST;
  logic [7:0]    KBCODE;
  logic          KBSTROBE;
  logic [9:0]    VCOORD;
  logic [7:0]    EV_CODE;
  logic          EV_RELEASE;
  logic          EV_VALID;
  logic          EV_READY;
  logic          OVERFLOW;
  logic [CW-1:0] FIFO_COUNT;

  int checks = 0;
  int errors = 0;

  // Model: queue of {release, code}; head stays queued while presented.
  logic [8:0] m_q[$];
  logic       m_bp;
  logic       m_ovf;
  logic       m_pres;
  logic       m_lv;
  logic [7:0] m_lm;

  always #20 CLK = ~CLK;

  kb_frame_scheduler #(
    .DEPTH(DEPTH),
    .VBLANK_LINE(10'd480),
    .BREAK_CODE(8'hF0)
  ) dut (
    .CLK(CLK), .RST(RST), .KBCODE(KBCODE), .KBSTROBE(KBSTROBE), .VCOORD(VCOORD),
    .EV_CODE(EV_CODE), .EV_RELEASE(EV_RELEASE), .EV_VALID(EV_VALID), .EV_READY(EV_READY),
    .OVERFLOW(OVERFLOW), .FIFO_COUNT(FIFO_COUNT)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic void m_key(input logic [7:0] c);
    logic rel;
    if (c == 8'hF0) begin
      m_bp = 1'b1;
      return;
    end
    rel  = m_bp;
    m_bp = 1'b0;
`ifdef KB_REPEAT_FILTER_EN
    if (rel) begin
      if (m_lv && c == m_lm) m_lv = 1'b0;
    end else if (m_lv && c == m_lm) begin
      return;
    end else begin
      m_lm = c;
      m_lv = 1'b1;
    end
`endif
    if (m_q.size() < DEPTH) m_q.push_back({rel, c});
    else m_ovf = 1'b1;
  endfunction

  task automatic do_reset();
    RST = 1'b1; KBSTROBE = 1'b0; EV_READY = 1'b0; VCOORD = 10'd0; KBCODE = 8'h00;
    step(2);
    RST = 1'b0;
    m_q.delete(); m_bp = 1'b0; m_ovf = 1'b0; m_pres = 1'b0; m_lv = 1'b0; m_lm = 8'h00;
    step(1);
  endtask

  task automatic key(input logic [7:0] c, input int hold);
    KBCODE = c; KBSTROBE = 1'b1;
    step(hold);
    KBSTROBE = 1'b0;
    step(1);
    m_key(c);
  endtask

  task automatic tick();
    VCOORD = 10'd479;
    step(1);
    VCOORD = 10'd480;
    step(1);
    if (!m_pres && m_q.size() > 0) m_pres = 1'b1;
  endtask

  task automatic accept();
    EV_READY = 1'b1;
    step(1);
    EV_READY = 1'b0;
    if (m_pres) begin
      void'(m_q.pop_front());
      m_pres = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({EV_VALID, EV_CODE, EV_RELEASE, OVERFLOW, FIFO_COUNT} !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b code=%h rel=%b ovf=%b cnt=%0d, required all zero",
               EV_VALID, EV_CODE, EV_RELEASE, OVERFLOW, FIFO_COUNT);
    end
  endtask

  task automatic test_single();
    do_reset();
    key(8'h1D, 5);
    checks++;
    if (FIFO_COUNT !== CW'(1)) begin
      errors++; $display("FAIL single_count: got %0d required 1", FIFO_COUNT);
    end
    VCOORD = 10'd479; step(1); VCOORD = 10'd480;
    checks++;
    if (EV_VALID !== 1'b0) begin
      errors++; $display("FAIL single_pre_tick_valid: got %b required 0", EV_VALID);
    end
    step(1);
    m_pres = 1'b1;
    checks++;
    if ({EV_VALID, EV_RELEASE, EV_CODE} !== {1'b1, 1'b0, 8'h1D}) begin
      errors++;
      $display("FAIL single_present: valid=%b rel=%b code=%h required 1 0 1d", EV_VALID, EV_RELEASE, EV_CODE);
    end
    accept();
    checks++;
    if ({EV_VALID, FIFO_COUNT} !== {1'b0, CW'(0)}) begin
      errors++; $display("FAIL single_accept: valid=%b cnt=%0d required 0 0", EV_VALID, FIFO_COUNT);
    end
  endtask

  task automatic test_break();
    do_reset();
    key(8'hF0, 3);
    key(8'h1D, 3);
    checks++;
    if (FIFO_COUNT !== CW'(1)) begin
      errors++; $display("FAIL break_count: got %0d required 1", FIFO_COUNT);
    end
    tick();
    checks++;
    if ({EV_VALID, EV_RELEASE, EV_CODE} !== {1'b1, 1'b1, 8'h1D}) begin
      errors++;
      $display("FAIL break_present: valid=%b rel=%b code=%h required 1 1 1d", EV_VALID, EV_RELEASE, EV_CODE);
    end
    accept();
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) key(8'(i), 2);
    checks++;
    if ({FIFO_COUNT, OVERFLOW} !== {CW'(4), 1'b1}) begin
      errors++; $display("FAIL ovf_state: cnt=%0d ovf=%b required 4 1", FIFO_COUNT, OVERFLOW);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({EV_VALID, EV_CODE} !== {1'b1, 8'(i)}) begin
        errors++; $display("FAIL ovf_order: valid=%b code=%h required 1 %h", EV_VALID, EV_CODE, 8'(i));
      end
      accept();
    end
    tick();
    checks++;
    if ({EV_VALID, FIFO_COUNT, OVERFLOW} !== {1'b0, CW'(0), 1'b1}) begin
      errors++;
      $display("FAIL ovf_drained: valid=%b cnt=%0d ovf=%b required 0 0 1", EV_VALID, FIFO_COUNT, OVERFLOW);
    end
  endtask

  task automatic test_hold();
    do_reset();
    key(8'h1C, 2);
    key(8'h2A, 2);
    tick();
    for (int f = 0; f < 3; f++) begin
      tick();
      checks++;
      if ({EV_VALID, EV_CODE, FIFO_COUNT} !== {1'b1, 8'h1C, CW'(2)}) begin
        errors++;
        $display("FAIL hold_stable: valid=%b code=%h cnt=%0d required 1 1c 2", EV_VALID, EV_CODE, FIFO_COUNT);
      end
    end
    accept();
    step(5);
    checks++;
    if ({EV_VALID, FIFO_COUNT} !== {1'b0, CW'(1)}) begin
      errors++; $display("FAIL hold_one_per_frame: valid=%b cnt=%0d required 0 1", EV_VALID, FIFO_COUNT);
    end
    tick();
    checks++;
    if ({EV_VALID, EV_CODE} !== {1'b1, 8'h2A}) begin
      errors++; $display("FAIL hold_second: valid=%b code=%h required 1 2a", EV_VALID, EV_CODE);
    end
    accept();
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int i = 0; i < 4; i++) key(8'h10 + 8'(i), 2);
    tick();
    KBCODE = 8'h14; KBSTROBE = 1'b1; EV_READY = 1'b1;
    step(1);
    EV_READY = 1'b0;
    void'(m_q.pop_front()); m_pres = 1'b0;
    m_key(8'h14);
    checks++;
    if ({FIFO_COUNT, OVERFLOW} !== {CW'(4), 1'b0}) begin
      errors++; $display("FAIL pushpop_full: cnt=%0d ovf=%b required 4 0", FIFO_COUNT, OVERFLOW);
    end
    KBSTROBE = 1'b0;
    step(1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({EV_VALID, EV_CODE} !== {1'b1, 8'h10 + 8'(i)}) begin
        errors++;
        $display("FAIL pushpop_order: valid=%b code=%h required 1 %h", EV_VALID, EV_CODE, 8'h10 + 8'(i));
      end
      accept();
    end
  endtask

  task automatic test_empty_tick();
    do_reset();
    tick();
    key(8'h33, 2);
    step(3);
    checks++;
    if (EV_VALID !== 1'b0) begin
      errors++; $display("FAIL empty_tick_forgotten: valid=%b required 0", EV_VALID);
    end
    tick();
    checks++;
    if ({EV_VALID, EV_CODE} !== {1'b1, 8'h33}) begin
      errors++; $display("FAIL empty_tick_next: valid=%b code=%h required 1 33", EV_VALID, EV_CODE);
    end
    accept();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 1; i <= 5; i++) key(8'h40 + 8'(i), 2);
    tick(); accept();
    tick();
    key(8'hF0, 2);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    checks++;
    if ({EV_VALID, FIFO_COUNT, OVERFLOW} !== {1'b0, CW'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: valid=%b cnt=%0d ovf=%b required 0 0 0", EV_VALID, FIFO_COUNT, OVERFLOW);
    end
    VCOORD = 10'd0;
    m_q.delete(); m_bp = 1'b0; m_ovf = 1'b0; m_pres = 1'b0; m_lv = 1'b0;
    step(1);
    key(8'h1D, 2);
    tick();
    checks++;
    if ({EV_VALID, EV_RELEASE, EV_CODE} !== {1'b1, 1'b0, 8'h1D}) begin
      errors++;
      $display("FAIL reset_clears_break: valid=%b rel=%b code=%h required 1 0 1d", EV_VALID, EV_RELEASE, EV_CODE);
    end
    accept();
  endtask

  task automatic test_repeat();
    logic [7:0] seq [6];
    logic [8:0] exp;
    seq = '{8'h1D, 8'h1D, 8'h1D, 8'hF0, 8'h1D, 8'h1D};
    do_reset();
    foreach (seq[i]) key(seq[i], 3);
    checks++;
    if ({FIFO_COUNT, OVERFLOW} !== {CW'(m_q.size()), m_ovf}) begin
      errors++;
      $display("FAIL repeat_count: cnt=%0d ovf=%b required %0d %b", FIFO_COUNT, OVERFLOW, m_q.size(), m_ovf);
    end
    while (m_q.size() > 0) begin
      exp = m_q[0];
      tick();
      checks++;
      if ({EV_VALID, EV_RELEASE, EV_CODE} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL repeat_order: valid=%b rel=%b code=%h required 1 %b %h",
                 EV_VALID, EV_RELEASE, EV_CODE, exp[8], exp[7:0]);
      end
      accept();
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic [8:0] exp;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        c = ($urandom_range(0, 3) == 0) ? 8'hF0 : 8'($urandom_range(1, 8'h0F));
        key(c, int'($urandom_range(1, 4)));
        checks++;
        if ({FIFO_COUNT, OVERFLOW} !== {CW'(m_q.size()), m_ovf}) begin
          errors++;
          $display("FAIL rand_count: cnt=%0d ovf=%b required %0d %b", FIFO_COUNT, OVERFLOW, m_q.size(), m_ovf);
        end
      end
      tick();
      if ($urandom_range(0, 2) == 0) tick();
      exp = m_pres ? m_q[0] : 9'h000;
      checks++;
      if (EV_VALID !== m_pres || (m_pres && {EV_RELEASE, EV_CODE} !== exp)) begin
        errors++;
        $display("FAIL rand_present: valid=%b rel=%b code=%h required %b %b %h",
                 EV_VALID, EV_RELEASE, EV_CODE, m_pres, exp[8], exp[7:0]);
      end
      if ($urandom_range(0, 3) != 0) accept();
      step(int'($urandom_range(1, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_overflow();
    test_hold();
    test_push_pop_full();
    test_empty_tick();
    test_reset_mid();
    test_repeat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
